// File: rtl/long_div_seq_ctrl_if.sv
// Handshake bundle for long_div_seq_ctrl.
//   master : request source / result consumer (drives in_valid, M, D, out_ready)
//   slave  : the divider sequencer (drives in_ready, out_valid, Q, R, ovf, div0)
// Signals:
//   in_valid/in_ready   operand handshake, M (4b divisor) and D (7b dividend)
//   out_valid/out_ready result handshake, Q (4b quotient) and R (4b remainder)
//   ovf                 quotient does not fit 4 bits, or M == 0
//   div0                M == 0
interface long_div_seq_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] M;
  logic [6:0] D;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] Q;
  logic [3:0] R;
  logic       ovf;
  logic       div0;

  modport master (
    output in_valid, M, D, out_ready,
    input  in_ready, out_valid, Q, R, ovf, div0
  );

  modport slave (
    input  in_valid, M, D, out_ready,
    output in_ready, out_valid, Q, R, ovf, div0
  );
endinterface

// File: rtl/long_div_seq_ctrl.sv
// Sequential 7-by-4 non-restoring divider. One 5-bit add/subtract row is reused for four
// quotient-bit iterations, followed by a single remainder-correction step.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any operation in flight
//   bus    long_div_seq_ctrl_if.slave (operand and result handshakes, Q/R/ovf/div0)
// Build option:
//   LONG_DIV_B2B_EN  when defined, in_ready is also high in DONE while out_ready is high, so a
//                    result and the next operands can be exchanged on the same edge.
module long_div_seq_ctrl (
  input logic               clk,
  input logic               rst_n,
  long_div_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

  state_e     state_q;
  logic [3:0] m_q;
  logic [6:0] d_q;
  logic [4:0] a_q;       // signed partial remainder
  logic [1:0] cnt_q;
  logic [3:0] qbits_q;
  logic [3:0] q_q;
  logic [3:0] r_q;
  logic       ovf_q;
  logic       div0_q;
  logic       out_valid_q;

  logic       accept;
  logic [4:0] m_ext;
  logic [1:0] bit_idx;
  logic [4:0] shifted;
  logic [4:0] a_next;
  logic [4:0] a_fix;

  always_comb begin
    m_ext   = {1'b0, m_q};
    bit_idx = 2'd3 - cnt_q;
    shifted = {a_q[3:0], d_q[bit_idx]};
    if (cnt_q == 2'd0) begin
      a_next = {1'b0, d_q[6:3]} - m_ext;
    end else if (!a_q[4]) begin
      // Previous quotient bit was 1: subtract.
      a_next = shifted - m_ext;
    end else begin
      a_next = shifted + m_ext;
    end
    a_fix = a_q + m_ext;
  end

`ifdef LONG_DIV_B2B_EN
  assign bus.in_ready = rst_n & ((state_q == StIdle) | ((state_q == StDone) & bus.out_ready));
`else
  assign bus.in_ready = rst_n & (state_q == StIdle);
`endif

  assign accept = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      m_q         <= '0;
      d_q         <= '0;
      a_q         <= '0;
      cnt_q       <= '0;
      qbits_q     <= '0;
      q_q         <= '0;
      r_q         <= '0;
      ovf_q       <= 1'b0;
      div0_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StIter: begin
          a_q              <= a_next;
          qbits_q[bit_idx] <= ~a_next[4];
          cnt_q            <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_q <= StFix;
        end
        StFix: begin
          q_q         <= qbits_q;
          r_q         <= a_q[4] ? a_fix[3:0] : a_q[3:0];
          ovf_q       <= 1'b0;
          div0_q      <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Operand load; placed last so a same-edge load in DONE overrides the return to IDLE.
      if (accept) begin
        m_q     <= bus.M;
        d_q     <= bus.D;
        a_q     <= '0;
        cnt_q   <= '0;
        qbits_q <= '0;
        if (bus.M == 4'd0) begin
          state_q     <= StDone;
          out_valid_q <= 1'b1;
          q_q         <= 4'hF;
          r_q         <= 4'h0;
          ovf_q       <= 1'b1;
          div0_q      <= 1'b1;
        end else if ({1'b0, bus.D[6:4]} >= bus.M) begin
          // Quotient would need more than 4 bits.
          state_q     <= StDone;
          out_valid_q <= 1'b1;
          q_q         <= 4'hF;
          r_q         <= 4'h0;
          ovf_q       <= 1'b1;
          div0_q      <= 1'b0;
        end else begin
          state_q <= StIter;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.Q         = q_q;
  assign bus.R         = r_q;
  assign bus.ovf       = ovf_q;
  assign bus.div0      = div0_q;

endmodule

// File: tb/tb_long_div_seq_ctrl.sv
module tb_long_div_seq_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  long_div_seq_ctrl_if bus ();

  long_div_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: plain integer division with the overflow / divide-by-zero rules.
  function automatic void ref_div(input int m, input int d, output int q, output int r,
                                  output bit ovf, output bit div0);
    if (m == 0) begin
      q = 15; r = 0; ovf = 1'b1; div0 = 1'b1;
    end else if (d / m > 15) begin
      q = 15; r = 0; ovf = 1'b1; div0 = 1'b0;
    end else begin
      q = d / m; r = d % m; ovf = 1'b0; div0 = 1'b0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands and return just after the handshake edge.
  task automatic send(input logic [3:0] m, input logic [6:0] d, input bit drop);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.M        = m;
    bus.D        = d;
    #1;
    while (!bus.in_ready && n < 30) begin
      step();
      n++;
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_in_ready: in_ready=%b required 1", bus.in_ready);
    end
    step();
    if (drop) begin
      bus.in_valid = 1'b0;
      bus.M        = 4'($urandom);
      bus.D        = 7'($urandom);
    end
  endtask

  // Clock edges after the handshake edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    tests++;
    if (bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL wait_out_timeout: out_valid=%b required 1", bus.out_valid);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #10;
    tests++;
    if ({bus.in_ready, bus.out_valid, bus.Q, bus.R, bus.ovf, bus.div0} !== 12'h000) begin
      fails++;
      $display("FAIL reset_state: rdy=%b vld=%b Q=%h R=%h ovf=%b div0=%b required all 0",
               bus.in_ready, bus.out_valid, bus.Q, bus.R, bus.ovf, bus.div0);
    end
    step();
    rst_n = 1'b1;
    #1;
    tests++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      fails++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0",
               bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_directed();
    logic [3:0] m_t [6] = '{4'd7, 4'd9, 4'd3, 4'd5, 4'd5, 4'd0};
    logic [6:0] d_t [6] = '{7'd100, 7'd127, 7'd45, 7'd0, 7'd100, 7'd50};
    int eq, er, lat;
    bit eo, ed;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ref_div(int'(m_t[i]), int'(d_t[i]), eq, er, eo, ed);
      send(m_t[i], d_t[i], 1'b1);
      wait_out(lat);
      tests++;
      if (lat != (eo ? 0 : 5)) begin
        fails++;
        $display("FAIL dir_latency[%0d]: %0d edges required %0d", i, lat, eo ? 0 : 5);
      end
      tests++;
      if ({bus.Q, bus.R, bus.ovf, bus.div0} !== {4'(eq), 4'(er), eo, ed}) begin
        fails++;
        $display("FAIL dir_result[%0d] D=%0d M=%0d: Q=%0d R=%0d ovf=%b div0=%b required %0d %0d %b %b",
                 i, d_t[i], m_t[i], bus.Q, bus.R, bus.ovf, bus.div0, eq, er, eo, ed);
      end
      step();
      tests++;
      if (bus.out_valid !== 1'b0) begin
        fails++;
        $display("FAIL dir_drop[%0d]: out_valid=%b required 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_random();
    int m, d, eq, er, lat, stall;
    bit eo, ed;
    for (int i = 0; i < 40; i++) begin
      m = $urandom_range(0, 15);
      d = $urandom_range(0, 127);
      if (m != 0 && $urandom_range(0, 3) != 0) d = $urandom_range(0, (16 * m - 1 > 127) ? 127 : 16 * m - 1);
      stall = $urandom_range(0, 3);
      ref_div(m, d, eq, er, eo, ed);
      bus.out_ready = (stall == 0);
      send(4'(m), 7'(d), 1'b1);
      wait_out(lat);
      tests++;
      if ({bus.Q, bus.R, bus.ovf, bus.div0} !== {4'(eq), 4'(er), eo, ed}) begin
        fails++;
        $display("FAIL rnd_result[%0d] D=%0d M=%0d: Q=%0d R=%0d ovf=%b div0=%b required %0d %0d %b %b",
                 i, d, m, bus.Q, bus.R, bus.ovf, bus.div0, eq, er, eo, ed);
      end
      if (!eo) begin
        tests++;
        if (int'(bus.Q) * m + int'(bus.R) != d || int'(bus.R) >= m) begin
          fails++;
          $display("FAIL rnd_invariant[%0d]: Q*M+R=%0d R=%0d required D=%0d R<%0d",
                   i, int'(bus.Q) * m + int'(bus.R), bus.R, d, m);
        end
      end
      for (int s = 0; s < stall; s++) begin
        step();
        tests++;
        if ({bus.out_valid, bus.Q, bus.R} !== {1'b1, 4'(eq), 4'(er)}) begin
          fails++;
          $display("FAIL rnd_hold[%0d]: vld=%b Q=%0d R=%0d required 1 %0d %0d",
                   i, bus.out_valid, bus.Q, bus.R, eq, er);
        end
      end
      bus.out_ready = 1'b1;
      step();
      tests++;
      if (bus.out_valid !== 1'b0) begin
        fails++;
        $display("FAIL rnd_drop[%0d]: out_valid=%b required 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_stall();
    int lat, n;
    bus.out_ready = 1'b0;
    send(4'd7, 7'd100, 1'b1);
    wait_out(lat);
    bus.in_valid = 1'b1;
    bus.M        = 4'd9;
    bus.D        = 7'd127;
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if ({bus.out_valid, bus.in_ready, bus.Q, bus.R} !== {1'b1, 1'b0, 4'd14, 4'd2}) begin
        fails++;
        $display("FAIL stall_hold[%0d]: vld=%b rdy=%b Q=%0d R=%0d required 1 0 14 2",
                 i, bus.out_valid, bus.in_ready, bus.Q, bus.R);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    n = 0;
    while (!bus.in_ready && n < 10) begin
      step();
      n++;
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_accept: in_ready=%b required 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    wait_out(lat);
    tests++;
    if ({bus.Q, bus.R, bus.ovf, bus.div0} !== {4'd14, 4'd1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL stall_next: Q=%0d R=%0d ovf=%b div0=%b required 14 1 0 0",
               bus.Q, bus.R, bus.ovf, bus.div0);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int lat;
    bus.out_ready = 1'b1;
    send(4'd7, 7'd100, 1'b1);
    step();
    step();
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.out_valid, bus.Q, bus.R, bus.ovf, bus.div0, bus.in_ready} !== 12'h000) begin
      fails++;
      $display("FAIL midreset_clear: vld=%b Q=%0d R=%0d ovf=%b div0=%b rdy=%b required all 0",
               bus.out_valid, bus.Q, bus.R, bus.ovf, bus.div0, bus.in_ready);
    end
    step();
    rst_n = 1'b1;
    #1;
    tests++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      fails++;
      $display("FAIL midreset_release: in_ready=%b out_valid=%b required 1 0",
               bus.in_ready, bus.out_valid);
    end
    send(4'd9, 7'd127, 1'b1);
    wait_out(lat);
    tests++;
    if ({bus.Q, bus.R, bus.ovf, bus.div0} !== {4'd14, 4'd1, 1'b0, 1'b0} || lat != 5) begin
      fails++;
      $display("FAIL midreset_after: Q=%0d R=%0d ovf=%b lat=%0d required 14 1 0 5",
               bus.Q, bus.R, bus.ovf, lat);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int t [2];
    logic [7:0] res [2];
    int got = 0;
    int n = 0;
    int exp_gap;
`ifdef LONG_DIV_B2B_EN
    exp_gap = 6;
`else
    exp_gap = 7;
`endif
    bus.out_ready = 1'b1;
    send(4'd7, 7'd100, 1'b0);
    bus.M = 4'd9;
    bus.D = 7'd127;
    while (got < 2 && n < 40) begin
      if (bus.out_valid) begin
        t[got]   = cyc;
        res[got] = {bus.Q, bus.R};
        got++;
        if (got == 2) bus.in_valid = 1'b0;
      end
      if (got < 2) step();
      n++;
    end
    tests++;
    if (got != 2) begin
      fails++;
      $display("FAIL b2b_count: %0d results required 2", got);
    end else begin
      tests++;
      if (t[1] - t[0] != exp_gap) begin
        fails++;
        $display("FAIL b2b_gap: %0d clocks required %0d", t[1] - t[0], exp_gap);
      end
      tests++;
      if ({res[0], res[1]} !== {4'd14, 4'd2, 4'd14, 4'd1}) begin
        fails++;
        $display("FAIL b2b_results: %h %h required e2 e1", res[0], res[1]);
      end
    end
    step();
    tests++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL b2b_end: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.M         = 4'd0;
    bus.D         = 7'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
